bus_sequencer: RTL and testbench
================================

# bus_sequencer

Control stage placed directly upstream of the W-bit tri-state bus datapath (input buffer, registers A–D, adder).
- Accepts one register-transfer command at a time over a valid/ready handshake.
- Expands each command into a cycle-accurate sequence of one-hot bus-drive enables and register-load strobes.
- Guarantees that at most one bus driver is enabled in any cycle, with a dead turnaround cycle after every drive.
- Reports completion, illegal commands and a count of completed operations.

## Interface
Parameters:
- CW, 8, width of the completed-operation counter

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; all state and outputs cleared while low
- cmdValid  in  1  command present
- cmdReady  out  1  sequencer can accept a command this cycle
- cmdOp  in  2  00 MOVE, 01 ADD, 10 BCAST, 11 illegal
- cmdSrc  in  3  0 inData, 1 A, 2 B, 3 C, 4 D, 5–7 illegal
- cmdDst  in  2  0 A, 1 B, 2 C, 3 D
- enbIn, enbA, enbB, enbC, enbD  out  1 each  bus-drive enables for input buffer and registers
- enbAdd  out  1  adder capture enable
- enbBusA  out  1  adder-result bus-drive enable
- ldA, ldB, ldC, ldD  out  1 each  register load strobes
- done  out  1  one-cycle pulse per completed command
- err  out  1  sticky illegal-command flag
- opCount  out  CW  completed-command count

## Operation
- All control outputs come straight from flops, with no combinational decode to the pins. The command fields are latched into internal registers on acceptance.
- States and transitions:
  - IDLE: cmdReady=1; all enables/loads 0. Handshake (cmdValid & cmdReady) latches fields. The next state depends on the command:
    - MOVE or BCAST with legal src → XFER
    - ADD → ADD_CALC
    - illegal (op 11 or src 5–7 with MOVE/BCAST) → IDLE, err set, command dropped, no done
  - XFER: exactly one src enable is high.
    - MOVE asserts the ld of dst only.
    - BCAST asserts ldA..ldD all.
    - Next state → TURN.
  - ADD_CALC: enbAdd=1; the adder captures A+B at the end of the cycle. cmdSrc is ignored. → ADD_WB.
  - ADD_WB: enbBusA=1 plus the ld of dst. → TURN.
  - TURN: all enables/loads 0; done=1; opCount increments. → IDLE.
- MOVE/BCAST with source register equal to a load target is legal; the register reloads its own value.
- ADD into A or B is legal; the adder value captured in ADD_CALC is written back.
- Arithmetic: opCount wraps modulo 2^CW, with no saturation and no flag.
- err stays set until reset.
- Invariant checked every cycle: popcount{enbIn,enbA,enbB,enbC,enbD,enbBusA} ≤ 1. enbAdd never overlaps any ld.
- Reset low at any time:
  - state → IDLE.
  - All enables, loads and done → 0, immediately without waiting for the clock.
  - err → 0 and opCount → 0.
  - An in-flight command is abandoned with no done.
- After reset release: cmdReady=1 from the first cycle.

## Timing
- Reset values: cmdReady=1; all enables, loads, done, err = 0; opCount=0.
- Acceptance is at clock edge E0 for a command presented while in IDLE.
- MOVE/BCAST:
  - Drive and load are high during the cycle E0→E1; the target register captures at E1.
  - done is high during E1→E2.
  - cmdReady returns high during E2→E3.
  - Period: 3 cycles per command.
- ADD:
  - enbAdd is high E0→E1.
  - enbBusA and ld are high E1→E2.
  - done is high E2→E3.
  - Period: 4 cycles per command.
- Illegal command: err rises after E0; cmdReady stays 1, so the next command can be accepted at E1.
- cmdValid held high with cmdReady=0 is ignored. Fields need only be stable in the acceptance cycle.
- Back-to-back commands with cmdValid held high: the TURN cycle always separates consecutive drive cycles.

## Test plan
- Reset then MOVE in→A with inData=0x1234: enbIn and ldA are high for exactly one cycle, then A=0x1234. done pulses 2 cycles after acceptance; opCount=1.
- With A=0x0005 and B=0x0007, ADD dst=C: enbAdd for one cycle, then enbBusA+ldC for one cycle, giving C=0x000C. done occurs on the 3rd cycle after acceptance.
- BCAST src=D with D=0xBEEF: enbD, ldA, ldB, ldC and ldD are high in the same single cycle, then all four registers equal 0xBEEF. No other enable is high.
- Illegal commands:
  - cmdOp=11: err=1, no enable toggles, no done, opCount unchanged.
  - A following legal MOVE at the next cycle completes normally.
- Stream of 260 MOVE commands with cmdValid held high:
  - Bus-contention invariant is never violated.
  - Exactly one TURN cycle between drives.
  - opCount wraps to 4 with CW=8.
- Assert reset during an ADD's ADD_WB cycle: ldX and enbBusA drop without a clock edge, and no done is produced. After release, cmdReady=1, opCount=0 and err=0.

Source files
------------

// File: rtl/bus_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// BusSequencer (module bus_sequencer)
//
// Control stage for the tri-state bus datapath built from an input buffer,
// registers A-D and an adder. It takes one register-transfer command at a
// time and turns it into a cycle-accurate sequence of one-hot bus-drive
// enables and register-load strobes. At most one bus driver is enabled in
// any cycle, and every drive is followed by a dead turnaround cycle.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous, active-low; clears all state and outputs
//   cmdValid         command present
//   cmdReady         sequencer can accept a command this cycle
//   cmdOp[1:0]       00 MOVE, 01 ADD, 10 BCAST, 11 illegal
//   cmdSrc[2:0]      0 inData, 1 A, 2 B, 3 C, 4 D, 5-7 illegal (ignored by ADD)
//   cmdDst[1:0]      0 A, 1 B, 2 C, 3 D
//   enbIn..enbD      bus-drive enables for the input buffer and registers
//   enbAdd           adder capture enable (adder takes A+B)
//   enbBusA          adder-result bus-drive enable
//   ldA..ldD         register load strobes
//   done             one-cycle pulse per completed command
//   err              sticky illegal-command flag
//   opCount[CW-1:0]  completed-command count, wraps modulo 2^CW
// ---------------------------------------------------------------------------
module bus_sequencer #(
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmdValid,
    output logic          cmdReady,
    input  logic [1:0]    cmdOp,
    input  logic [2:0]    cmdSrc,
    input  logic [1:0]    cmdDst,
    output logic          enbIn,
    output logic          enbA,
    output logic          enbB,
    output logic          enbC,
    output logic          enbD,
    output logic          enbAdd,
    output logic          enbBusA,
    output logic          ldA,
    output logic          ldB,
    output logic          ldC,
    output logic          ldD,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] opCount
);

    typedef enum logic [2:0] {
        IDLE,
        XFER,
        ADD_CALC,
        ADD_WB,
        TURN
    } stateT;

    localparam logic [1:0] OP_MOVE  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_BCAST = 2'b10;

    stateT      state;
    logic [1:0] dstReg;
    logic [4:0] driveReg;
    logic [3:0] ldReg;
    logic       enbAddReg;
    logic       enbBusAReg;

    // Source field to one-hot drive enable {D,C,B,A,In}; illegal codes give
    // no enable at all.
    function automatic logic [4:0] srcDecode(input logic [2:0] src);
        logic [4:0] oneHot;
        oneHot = 5'b00000;
        case (src)
            3'd0:    oneHot = 5'b00001;
            3'd1:    oneHot = 5'b00010;
            3'd2:    oneHot = 5'b00100;
            3'd3:    oneHot = 5'b01000;
            3'd4:    oneHot = 5'b10000;
            default: oneHot = 5'b00000;
        endcase
        return oneHot;
    endfunction

    // Destination field to one-hot load strobe {D,C,B,A}.
    function automatic logic [3:0] dstDecode(input logic [1:0] dst);
        return 4'b0001 << dst;
    endfunction

    // Every output is a flop, so the pins carry no decode glitches. The
    // enables for a cycle are computed one edge early: the drive pattern of
    // the first command cycle is loaded on the accepting edge itself, which
    // is why acceptance decodes the incoming fields directly. Only the
    // destination is kept afterwards, because the ADD writeback is the only
    // later step that still needs a command field. Anything not explicitly
    // set in a state falls back to zero, which gives the dead turnaround
    // cycle and the single-cycle pulses for free.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            dstReg     <= 2'd0;
            driveReg   <= 5'b00000;
            ldReg      <= 4'b0000;
            enbAddReg  <= 1'b0;
            enbBusAReg <= 1'b0;
            done       <= 1'b0;
            cmdReady   <= 1'b1;
            err        <= 1'b0;
            opCount    <= '0;
        end else begin
            driveReg   <= 5'b00000;
            ldReg      <= 4'b0000;
            enbAddReg  <= 1'b0;
            enbBusAReg <= 1'b0;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmdValid && cmdReady) begin
                        dstReg <= cmdDst;
                        if (cmdOp == OP_ADD) begin
                            state     <= ADD_CALC;
                            enbAddReg <= 1'b1;
                            cmdReady  <= 1'b0;
                        end else if ((cmdOp == OP_MOVE || cmdOp == OP_BCAST) &&
                                     (cmdSrc <= 3'd4)) begin
                            state    <= XFER;
                            driveReg <= srcDecode(cmdSrc);
                            ldReg    <= (cmdOp == OP_BCAST) ? 4'b1111 : dstDecode(cmdDst);
                            cmdReady <= 1'b0;
                        end else begin
                            // Illegal commands are dropped on the spot; the
                            // sequencer stays ready for the next cycle.
                            err <= 1'b1;
                        end
                    end
                end

                XFER: begin
                    state   <= TURN;
                    done    <= 1'b1;
                    opCount <= opCount + CW'(1);
                end

                ADD_CALC: begin
                    state      <= ADD_WB;
                    enbBusAReg <= 1'b1;
                    ldReg      <= dstDecode(dstReg);
                end

                ADD_WB: begin
                    state   <= TURN;
                    done    <= 1'b1;
                    opCount <= opCount + CW'(1);
                end

                TURN: begin
                    state    <= IDLE;
                    cmdReady <= 1'b1;
                end

                default: begin
                    state    <= IDLE;
                    cmdReady <= 1'b1;
                end
            endcase
        end
    end

    assign {enbD, enbC, enbB, enbA, enbIn} = driveReg;
    assign {ldD, ldC, ldB, ldA}            = ldReg;
    assign enbAdd                          = enbAddReg;
    assign enbBusA                         = enbBusAReg;

endmodule

// File: tb/tb_bus_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Testbench for bus_sequencer.
//
// A small behavioural model of the W=16 bus datapath (input buffer, A-D,
// adder) is driven by the sequencer's enables. Each issued command pushes
// its expected completion (opCount value and destination register contents)
// into a scoreboard queue; a monitor pops and compares on every done pulse.
// Per-cycle control patterns are checked directly by the stimulus task, and
// a second monitor checks bus contention every cycle.
// ---------------------------------------------------------------------------
module tb_bus_sequencer;

    typedef struct {
        logic [7:0]  count;
        logic [3:0]  mask;
        logic [15:0] value;
    } expT;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmdValid;
    logic        cmdReady;
    logic [1:0]  cmdOp;
    logic [2:0]  cmdSrc;
    logic [1:0]  cmdDst;
    logic        enbIn, enbA, enbB, enbC, enbD;
    logic        enbAdd, enbBusA;
    logic        ldA, ldB, ldC, ldD;
    logic        done;
    logic        err;
    logic [7:0]  opCount;

    int          total = 0;
    int          bad   = 0;
    expT         sb[$];
    logic [7:0]  expCount;

    logic [15:0] inData;
    logic [15:0] regs[4];
    logic [15:0] adderReg;
    logic [15:0] busVal;
    logic [5:0]  drives;
    logic [3:0]  lds;
    logic [12:0] ctlVec;

    always #5 clock = ~clock;

    bus_sequencer #(.CW(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .cmdValid (cmdValid),
        .cmdReady (cmdReady),
        .cmdOp    (cmdOp),
        .cmdSrc   (cmdSrc),
        .cmdDst   (cmdDst),
        .enbIn    (enbIn),
        .enbA     (enbA),
        .enbB     (enbB),
        .enbC     (enbC),
        .enbD     (enbD),
        .enbAdd   (enbAdd),
        .enbBusA  (enbBusA),
        .ldA      (ldA),
        .ldB      (ldB),
        .ldC      (ldC),
        .ldD      (ldD),
        .done     (done),
        .err      (err),
        .opCount  (opCount)
    );

    assign drives = {enbBusA, enbD, enbC, enbB, enbA, enbIn};
    assign lds    = {ldD, ldC, ldB, ldA};
    assign ctlVec = {enbAdd, drives, lds, done, cmdReady};

    // Bus value seen by the datapath for the current drive pattern.
    always_comb begin
        busVal = 16'h0000;
        case (drives)
            6'b000001: busVal = inData;
            6'b000010: busVal = regs[0];
            6'b000100: busVal = regs[1];
            6'b001000: busVal = regs[2];
            6'b010000: busVal = regs[3];
            6'b100000: busVal = adderReg;
            default:   busVal = 16'h0000;
        endcase
    end

    // Datapath model: adder captures A+B, registers load from the bus.
    always @(posedge clock) begin
        if (enbAdd) adderReg <= regs[0] + regs[1];
        for (int i = 0; i < 4; i++) begin
            if (lds[i]) regs[i] <= busVal;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExpect(input logic [3:0] mask, input logic [15:0] value);
        expT e;
        expCount = expCount + 8'd1;
        e.count  = expCount;
        e.mask   = mask;
        e.value  = value;
        sb.push_back(e);
    endtask

    // Issues one legal command at the current negedge (sequencer idle) and
    // checks the control pattern of every following cycle.
    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] src,
                                 input logic [1:0] dst, input logic [5:0] expDrive,
                                 input logic [3:0] expLd);
        cmdOp    = op;
        cmdSrc   = src;
        cmdDst   = dst;
        cmdValid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmdValid = 1'b0;
        cmdOp    = 2'b11;
        cmdSrc   = 3'd7;
        cmdDst   = ~dst;
        if (op == 2'b01) begin
            checkOutput("addCalc", 32'(ctlVec), 32'({1'b1, 6'b000000, 4'b0000, 1'b0, 1'b0}));
            @(negedge clock);
            checkOutput("addWb", 32'(ctlVec), 32'({1'b0, expDrive, expLd, 1'b0, 1'b0}));
        end else begin
            checkOutput("xfer", 32'(ctlVec), 32'({1'b0, expDrive, expLd, 1'b0, 1'b0}));
        end
        @(negedge clock);
        checkOutput("turnDone", 32'(ctlVec), 32'({1'b0, 6'b000000, 4'b0000, 1'b1, 1'b0}));
        @(negedge clock);
        checkOutput("readyAgain", 32'(ctlVec), 32'({1'b0, 6'b000000, 4'b0000, 1'b0, 1'b1}));
    endtask

    // Scoreboard monitor and per-cycle contention check.
    always @(negedge clock) begin
        expT  e;
        logic contention;
        if (reset === 1'b1) begin
            contention = ($countones(drives) > 1) || (enbAdd && (|lds));
            checkOutput("busContention", 32'(contention), 32'd0);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpectedDone", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("opCount", 32'(opCount), 32'(e.count));
                    for (int i = 0; i < 4; i++) begin
                        if (e.mask[i]) checkOutput("regValue", 32'(regs[i]), 32'(e.value));
                    end
                end
            end
        end
    end

    initial begin
        #200us;
        $display("[TB] FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset    = 1'b0;
        cmdValid = 1'b0;
        cmdOp    = 2'b00;
        cmdSrc   = 3'd0;
        cmdDst   = 2'd0;
        inData   = 16'h0000;
        expCount = 8'd0;

        #12;
        checkOutput("resetCtl", 32'({ctlVec, err}), 32'({13'b0_000000_0000_0_1, 1'b0}));
        checkOutput("resetCount", 32'(opCount), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        checkOutput("readyAfterRelease", 32'(cmdReady), 32'd1);

        // Directed register transfers.
        inData = 16'h1234; pushExpect(4'b0001, 16'h1234);
        applyStimulus(2'b00, 3'd0, 2'd0, 6'b000001, 4'b0001);
        inData = 16'h0005; pushExpect(4'b0001, 16'h0005);
        applyStimulus(2'b00, 3'd0, 2'd0, 6'b000001, 4'b0001);
        inData = 16'h0007; pushExpect(4'b0010, 16'h0007);
        applyStimulus(2'b00, 3'd0, 2'd1, 6'b000001, 4'b0010);
        pushExpect(4'b0100, 16'h000C);
        applyStimulus(2'b01, 3'd6, 2'd2, 6'b100000, 4'b0100);
        inData = 16'hBEEF; pushExpect(4'b1000, 16'hBEEF);
        applyStimulus(2'b00, 3'd0, 2'd3, 6'b000001, 4'b1000);
        inData = 16'h0000; pushExpect(4'b1111, 16'hBEEF);
        applyStimulus(2'b10, 3'd4, 2'd0, 6'b010000, 4'b1111);
        pushExpect(4'b0001, 16'h7DDE);
        applyStimulus(2'b01, 3'd0, 2'd0, 6'b100000, 4'b0001);
        pushExpect(4'b0001, 16'h7DDE);
        applyStimulus(2'b00, 3'd1, 2'd0, 6'b000010, 4'b0001);

        // Illegal opcode followed by a legal MOVE on the very next cycle.
        cmdOp = 2'b11; cmdSrc = 3'd0; cmdDst = 2'd0; cmdValid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkOutput("illegalOpCtl", 32'({ctlVec, err}), 32'({13'b0_000000_0000_0_1, 1'b1}));
        checkOutput("illegalOpCount", 32'(opCount), 32'd8);
        inData = 16'h4321; pushExpect(4'b0010, 16'h4321);
        applyStimulus(2'b00, 3'd0, 2'd1, 6'b000001, 4'b0010);
        checkOutput("errSticky", 32'(err), 32'd1);

        // Illegal source on a MOVE.
        cmdOp = 2'b00; cmdSrc = 3'd5; cmdDst = 2'd2; cmdValid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmdValid = 1'b0;
        checkOutput("illegalSrcCtl", 32'({ctlVec, err}), 32'({13'b0_000000_0000_0_1, 1'b1}));
        checkOutput("illegalSrcCount", 32'(opCount), 32'd9);

        // Reset asserted during the ADD writeback cycle.
        cmdOp = 2'b01; cmdSrc = 3'd0; cmdDst = 2'd1; cmdValid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmdValid = 1'b0;
        @(posedge clock);
        #2;
        checkOutput("addWbBeforeReset", 32'({enbBusA, ldB}), 32'({1'b1, 1'b1}));
        reset    = 1'b0;
        expCount = 8'd0;
        #1;
        checkOutput("asyncDrop", 32'({ctlVec, err}), 32'({13'b0_000000_0000_0_1, 1'b0}));
        checkOutput("asyncCount", 32'(opCount), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        checkOutput("postReleaseCtl", 32'({ctlVec, err}), 32'({13'b0_000000_0000_0_1, 1'b0}));
        checkOutput("sbEmptyBeforeStream", 32'(sb.size()), 32'd0);

        // Stream of 260 MOVE in->A with cmdValid held high.
        cmdOp = 2'b00; cmdSrc = 3'd0; cmdDst = 2'd0; cmdValid = 1'b1;
        for (int k = 0; k < 260; k++) begin
            inData = 16'h1000 + 16'(k);
            pushExpect(4'b0001, inData);
            @(posedge clock);
            @(negedge clock);
            checkOutput("streamDrive", 32'(ctlVec), 32'({1'b0, 6'b000001, 4'b0001, 1'b0, 1'b0}));
            @(negedge clock);
            checkOutput("streamTurn", 32'(ctlVec), 32'({1'b0, 6'b000000, 4'b0000, 1'b1, 1'b0}));
            @(negedge clock);
            if (k == 259) cmdValid = 1'b0;
            checkOutput("streamIdle", 32'(ctlVec), 32'({1'b0, 6'b000000, 4'b0000, 1'b0, 1'b1}));
        end
        @(negedge clock);
        @(negedge clock);
        checkOutput("wrapCount", 32'(opCount), 32'd4);
        checkOutput("sbDrained", 32'(sb.size()), 32'd0);
        checkOutput("errClear", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
